// File: rtl/reorder_buf_inord.sv
// In-order release buffer for DMA read completions: tags granted in ring order, beats stored per tag, whole tags drained in grant order.
// First out_vld two cycles after the head tag's last beat is stored; out_rdy low holds the beat, one bubble between tags, st_rdy always high.
module reorder_buf_inord #(
    parameter int TAG_NUM_LOG = 5,
    parameter int DATA_W      = 256,
    parameter int SLOT_LOG    = 2
) (
    input  logic                   dma_clk,
    input  logic                   rst,
    input  logic                   alloc_req,
    output logic                   alloc_gnt,
    output logic [TAG_NUM_LOG-1:0] alloc_tag,
    input  logic                   st_wen,
    input  logic [TAG_NUM_LOG-1:0] st_tag,
    input  logic                   st_last,
    input  logic [DATA_W-1:0]      st_data,
    output logic                   st_rdy,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [TAG_NUM_LOG-1:0] out_tag,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [TAG_NUM_LOG:0]   inflight,
    output logic                   err_unalloc,
    output logic                   err_ovf
);

    localparam int TAG_NUM    = 1 << TAG_NUM_LOG;
    localparam int SLOT_DEPTH = 1 << SLOT_LOG;
    localparam int ADDR_W     = TAG_NUM_LOG + SLOT_LOG;

    localparam logic [TAG_NUM_LOG-1:0] TAG_ONE  = {{(TAG_NUM_LOG-1){1'b0}}, 1'b1};
    localparam logic [TAG_NUM_LOG:0]   TAG_FULL = {1'b1, {TAG_NUM_LOG{1'b0}}};
    localparam logic [TAG_NUM_LOG:0]   INF_ONE  = {{TAG_NUM_LOG{1'b0}}, 1'b1};
    localparam logic [SLOT_LOG:0]      CNT_ONE  = {{SLOT_LOG{1'b0}}, 1'b1};
    localparam logic [SLOT_LOG:0]      CNT_FULL = {1'b1, {SLOT_LOG{1'b0}}};

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                            state_q, state_d;
    logic [TAG_NUM_LOG-1:0]            head_q, head_d;
    logic [TAG_NUM_LOG-1:0]            tail_q, tail_d;
    logic [TAG_NUM_LOG:0]              inflight_q, inflight_d;
    logic [TAG_NUM-1:0]                alloc_q, alloc_d;
    logic [TAG_NUM-1:0]                done_q, done_d;
    logic [TAG_NUM-1:0][SLOT_LOG:0]    wcnt_q, wcnt_d;
    logic [TAG_NUM-1:0][SLOT_LOG:0]    nbeat_q, nbeat_d;
    logic [SLOT_LOG:0]                 rbeat_q, rbeat_d;
    logic                              out_vld_q, out_vld_d;
    logic [TAG_NUM_LOG-1:0]            out_tag_q, out_tag_d;
    logic [DATA_W-1:0]                 out_data_q, out_data_d;
    logic                              out_last_q, out_last_d;
    logic                              err_unalloc_q, err_unalloc_d;
    logic                              err_ovf_q, err_ovf_d;

    logic [DATA_W-1:0]                 mem_q [TAG_NUM*SLOT_DEPTH];
    logic                              mem_we;
    logic [ADDR_W-1:0]                 mem_waddr;
    logic [DATA_W-1:0]                 mem_wdata;

    logic                              st_live;
    logic                              st_full;
    logic                              rel_fire;

    assign alloc_gnt = alloc_req && (inflight_q != TAG_FULL);
    assign alloc_tag = tail_q;
    assign st_live   = alloc_q[st_tag] && !done_q[st_tag];
    assign st_full   = (wcnt_q[st_tag] == CNT_FULL);
    assign rel_fire  = (state_q == DRAIN) && out_rdy && out_last_q;

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        alloc_d       = alloc_q;
        done_d        = done_q;
        wcnt_d        = wcnt_q;
        nbeat_d       = nbeat_q;
        rbeat_d       = rbeat_q;
        out_vld_d     = out_vld_q;
        out_tag_d     = out_tag_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        mem_we        = 1'b0;
        mem_waddr     = {st_tag, wcnt_q[st_tag][SLOT_LOG-1:0]};
        mem_wdata     = st_data;
        err_unalloc_d = st_wen && !st_live;
        err_ovf_d     = st_wen && st_live && st_full;

        if (alloc_gnt) begin
            alloc_d[tail_q] = 1'b1;
            tail_d          = tail_q + TAG_ONE;
        end

        // An overflowing last beat is dropped but still closes the tag at SLOT_DEPTH beats.
        if (st_wen && st_live) begin
            if (!st_full) begin
                mem_we          = 1'b1;
                wcnt_d[st_tag]  = wcnt_q[st_tag] + CNT_ONE;
            end
            if (st_last) begin
                done_d[st_tag]  = 1'b1;
                nbeat_d[st_tag] = st_full ? wcnt_q[st_tag] : (wcnt_q[st_tag] + CNT_ONE);
            end
        end

        case (state_q)
            IDLE: begin
                if (alloc_q[head_q] && done_q[head_q]) begin
                    out_data_d = mem_q[{head_q, {SLOT_LOG{1'b0}}}];
                    out_tag_d  = head_q;
                    out_last_d = (nbeat_q[head_q] == CNT_ONE);
                    rbeat_d    = CNT_ONE;
                    out_vld_d  = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (out_rdy) begin
                    if (!out_last_q) begin
                        out_data_d = mem_q[{head_q, rbeat_q[SLOT_LOG-1:0]}];
                        out_last_d = ((rbeat_q + CNT_ONE) == nbeat_q[head_q]);
                        rbeat_d    = rbeat_q + CNT_ONE;
                    end else begin
                        alloc_d[head_q] = 1'b0;
                        done_d[head_q]  = 1'b0;
                        wcnt_d[head_q]  = '0;
                        head_d          = head_q + TAG_ONE;
                        out_vld_d       = 1'b0;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d = inflight_q;
        if (alloc_gnt && !rel_fire) begin
            inflight_d = inflight_q + INF_ONE;
        end else if (!alloc_gnt && rel_fire) begin
            inflight_d = inflight_q - INF_ONE;
        end
    end

    always_ff @(posedge dma_clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            inflight_q    <= '0;
            alloc_q       <= '0;
            done_q        <= '0;
            wcnt_q        <= '0;
            nbeat_q       <= '0;
            rbeat_q       <= '0;
            out_vld_q     <= 1'b0;
            out_tag_q     <= '0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            err_unalloc_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            inflight_q    <= inflight_d;
            alloc_q       <= alloc_d;
            done_q        <= done_d;
            wcnt_q        <= wcnt_d;
            nbeat_q       <= nbeat_d;
            rbeat_q       <= rbeat_d;
            out_vld_q     <= out_vld_d;
            out_tag_q     <= out_tag_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            err_unalloc_q <= err_unalloc_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    always_ff @(posedge dma_clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign st_rdy      = 1'b1;
    assign out_vld     = out_vld_q;
    assign out_tag     = out_tag_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign inflight    = inflight_q;
    assign err_unalloc = err_unalloc_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_reorder_buf_inord.sv
// Directed bench for reorder_buf_inord (8 tags, 4 beats/tag, 32-bit data) with an expected-beat scoreboard.
module tb_reorder_buf_inord;

    localparam int TNL = 3;
    localparam int DW  = 32;
    localparam int SL  = 2;

    typedef struct packed {
        logic [TNL-1:0] tag;
        logic [DW-1:0]  data;
        logic           last;
    } beat_t;

    logic           dma_clk;
    logic           rst;
    logic           alloc_req;
    logic           alloc_gnt;
    logic [TNL-1:0] alloc_tag;
    logic           st_wen;
    logic [TNL-1:0] st_tag;
    logic           st_last;
    logic [DW-1:0]  st_data;
    logic           st_rdy;
    logic           out_vld;
    logic           out_rdy;
    logic [TNL-1:0] out_tag;
    logic [DW-1:0]  out_data;
    logic           out_last;
    logic [TNL:0]   inflight;
    logic           err_unalloc;
    logic           err_ovf;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];
    beat_t mon_b;

    reorder_buf_inord #(.TAG_NUM_LOG(TNL), .DATA_W(DW), .SLOT_LOG(SL)) dut (
        .dma_clk(dma_clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .st_wen(st_wen), .st_tag(st_tag), .st_last(st_last), .st_data(st_data), .st_rdy(st_rdy),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_tag(out_tag), .out_data(out_data), .out_last(out_last),
        .inflight(inflight), .err_unalloc(err_unalloc), .err_ovf(err_ovf)
    );

    initial dma_clk = 1'b0;
    always #5 dma_clk = ~dma_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Each accepted output beat is matched against the oldest expected beat.
    always @(negedge dma_clk) begin
        if (!rst && out_vld && out_rdy) begin
            chk("beat_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                mon_b = exp_q.pop_front();
                chk("out_tag", 64'(out_tag), 64'(mon_b.tag));
                chk("out_data", 64'(out_data), 64'(mon_b.data));
                chk("out_last", 64'(out_last), 64'(mon_b.last));
            end
        end
    end

    task automatic tick();
        @(posedge dma_clk);
        #1;
    endtask

    task automatic push(input logic [TNL-1:0] t, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.tag = t; b.data = d; b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic alloc_one(input logic [TNL-1:0] exp_tag);
        alloc_req = 1'b1;
        #1;
        chk("alloc_gnt", 64'(alloc_gnt), 64'(1));
        chk("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
        tick();
        alloc_req = 1'b0;
    endtask

    task automatic store(input logic [TNL-1:0] t, input logic [DW-1:0] d, input logic l);
        st_wen = 1'b1; st_tag = t; st_data = d; st_last = l;
        tick();
        st_wen = 1'b0; st_last = 1'b0;
    endtask

    task automatic wait_vld();
        for (int n = 0; n < 100; n++) begin
            if (out_vld) break;
            tick();
        end
        chk("wait_out_vld", 64'(out_vld), 64'(1));
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_complete", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    int          seq[7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [DW-1:0] prev_data;

    initial begin
        rst = 1'b1; alloc_req = 1'b0; st_wen = 1'b0; st_tag = '0; st_last = 1'b0;
        st_data = '0; out_rdy = 1'b0;
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_inflight", 64'(inflight), 64'(0));
        chk("rst_st_rdy", 64'(st_rdy), 64'(1));
        chk("rst_errs", 64'({err_unalloc, err_ovf}), 64'(0));
        chk("rst_out_bus", 64'({out_tag, out_data, out_last}), 64'(0));
        chk("rst_alloc_gnt", 64'(alloc_gnt), 64'(0));
        tick();
        tick();
        rst = 1'b0;

        // 1: three grants, two-beat completion on tag 0, two-cycle latency
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) alloc_one(TNL'(i));
        chk("t1_inflight3", 64'(inflight), 64'(3));
        push(0, 32'hD0D0_0000, 1'b0);
        push(0, 32'hD1D1_0001, 1'b1);
        store(0, 32'hD0D0_0000, 1'b0);
        store(0, 32'hD1D1_0001, 1'b1);
        chk("t1_vld_lat1", 64'(out_vld), 64'(0));
        tick();
        chk("t1_vld_lat2", 64'(out_vld), 64'(1));
        chk("t1_first_data", 64'(out_data), 64'(32'hD0D0_0000));
        wait_drain();
        tick();
        chk("t1_inflight2", 64'(inflight), 64'(2));

        // 2: out-of-order completion, in-order release with one bubble per tag
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) alloc_one(TNL'(i));
        for (int i = 0; i < 4; i++) push(TNL'(i), 32'(i * 16), 1'b1);
        store(3, 32'h30, 1'b1);
        store(1, 32'h10, 1'b1);
        store(2, 32'h20, 1'b1);
        tick();
        chk("t2_parked", 64'(out_vld), 64'(0));
        store(0, 32'h00, 1'b1);
        chk("t2_vld_lat1", 64'(out_vld), 64'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_bubble", 64'(out_vld), 64'(i % 2 == 0));
        end
        chk("t2_all_out", 64'(exp_q.size()), 64'(0));
        chk("t2_inflight0", 64'(inflight), 64'(0));

        // 3: full ring refuses grants; freed tag 0 re-granted the cycle after release
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) alloc_one(TNL'(i));
        alloc_req = 1'b1;
        #1;
        chk("t3_full_gnt", 64'(alloc_gnt), 64'(0));
        tick();
        chk("t3_full_inflight", 64'(inflight), 64'(8));
        chk("t3_full_gnt2", 64'(alloc_gnt), 64'(0));
        alloc_req = 1'b0;
        push(0, 32'hA5, 1'b1);
        store(0, 32'hA5, 1'b1);
        wait_drain();
        chk("t3_after_rel", 64'(inflight), 64'(7));
        alloc_one(0);
        chk("t3_inflight8", 64'(inflight), 64'(8));

        // 4: store to unallocated tag, then slot overflow
        do_reset();
        out_rdy = 1'b1;
        store(5, 32'hBAD, 1'b1);
        chk("t4_err_unalloc", 64'(err_unalloc), 64'(1));
        tick();
        chk("t4_err_unalloc_pulse", 64'(err_unalloc), 64'(0));
        chk("t4_no_state", 64'({out_vld, inflight}), 64'(0));
        alloc_one(0);
        for (int i = 0; i < 4; i++) push(0, 32'h40 + 32'(i), i == 3);
        for (int i = 0; i < 4; i++) store(0, 32'h40 + 32'(i), 1'b0);
        chk("t4_no_ovf_yet", 64'(err_ovf), 64'(0));
        store(0, 32'h44, 1'b1);
        chk("t4_err_ovf", 64'(err_ovf), 64'(1));
        tick();
        chk("t4_err_ovf_pulse", 64'(err_ovf), 64'(0));
        wait_drain();
        tick();
        tick();
        chk("t4_no_extra", 64'(out_vld), 64'(0));
        chk("t4_inflight0", 64'(inflight), 64'(0));

        // 5: four-beat tag drained under an out_rdy stall pattern
        out_rdy = 1'b0;
        alloc_one(1);
        for (int i = 0; i < 4; i++) push(1, 32'h50 + 32'(i), i == 3);
        for (int i = 0; i < 4; i++) store(1, 32'h50 + 32'(i), i == 3);
        wait_vld();
        for (int i = 0; i < 7; i++) begin
            out_rdy = seq[i][0];
            prev_data = out_data;
            tick();
            if (seq[i] == 0) begin
                chk("t5_stall_data", 64'(out_data), 64'(prev_data));
                chk("t5_stall_vld", 64'(out_vld), 64'(1));
            end
        end
        chk("t5_all_out", 64'(exp_q.size()), 64'(0));
        chk("t5_vld_low", 64'(out_vld), 64'(0));

        // 6: reset mid-drain aborts, tag numbering restarts
        out_rdy = 1'b0;
        alloc_one(2);
        push(2, 32'h60, 1'b0);
        push(2, 32'h61, 1'b0);
        for (int i = 0; i < 4; i++) store(2, 32'h60 + 32'(i), i == 3);
        wait_vld();
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("t6_pending_data", 64'(out_data), 64'(32'h61));
        chk("t6_pending_vld", 64'(out_vld), 64'(1));
        rst = 1'b1;
        #1;
        chk("t6_rst_vld", 64'(out_vld), 64'(0));
        chk("t6_rst_inflight", 64'(inflight), 64'(0));
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_no_ghost", 64'(out_vld), 64'(0));
        alloc_one(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
